ram: RTL and testbench

- Single-port synchronous static RAM: 32 words × 32 bits.
- A chip enable (cen) and a write enable (wen) select the operation each clock: write, registered read, or idle.
- General-purpose storage block, instantiated directly by datapath or controller logic; no handshake beyond the enables.

---
 rtl/ram.sv | 36 +++
 tb/tb_ram.sv | 131 +++++++++++++
 2 files changed

// File: rtl/ram.sv
// rtl/ram.sv - single-port synchronous RAM with registered read data
// Reset clears every word; idle and write cycles drive dout to zero.
module ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cen,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            dout <= '0;
        end else if (!cen) begin
            dout <= '0;
        end else if (wen) begin
            // No write-through: a write cycle presents zero on dout.
            mem[addr] <= din;
            dout      <= '0;
        end else begin
            dout <= mem[addr];
        end
    end

endmodule

// File: tb/tb_ram.sv
// tb/tb_ram.sv - self-checking bench for ram against an array reference model
module tb_ram;

    logic        clk;
    logic        rst;
    logic        cen;
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [32];
    logic [31:0] exp_dout;

    ram #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .cen  (cen),
        .wen  (wen),
        .addr (addr),
        .din  (din),
        .dout (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Junk is driven between edges first, then the real values, so any
    // sensitivity to mid-cycle input changes shows up as a wrong result.
    task automatic step(input logic r, input logic c, input logic w,
                        input logic [4:0] a, input logic [31:0] d,
                        input string tag);
        rst  = $urandom_range(0, 1);
        cen  = $urandom_range(0, 1);
        wen  = $urandom_range(0, 1);
        addr = 5'($urandom);
        din  = $urandom;
        #3;
        rst  = r;
        cen  = c;
        wen  = w;
        addr = a;
        din  = d;
        @(posedge clk);
        if (r) begin
            foreach (model[i]) model[i] = 32'h0;
            exp_dout = 32'h0;
        end else if (!c) begin
            exp_dout = 32'h0;
        end else if (w) begin
            model[a] = d;
            exp_dout = 32'h0;
        end else begin
            exp_dout = model[a];
        end
        #1;
        checks++;
        assert (dout === exp_dout) else begin
            errors++;
            $error("FAIL %s: addr=%0d dout=%h expected=%h", tag, a, dout, exp_dout);
        end
    endtask

    logic [31:0] seq_data [17];
    logic [31:0] d0;
    logic [31:0] d31;

    initial begin
        seq_data = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'h8,
                     32'h9, 32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16};
        rst = 1'b0; cen = 1'b0; wen = 1'b0; addr = '0; din = '0;
        foreach (model[i]) model[i] = 32'hx;
        @(negedge clk);
        #1;

        // Reset overrides a concurrent write to addr 3.
        step(1'b1, 1'b1, 1'b1, 5'd3, 32'hFFFF_FFFF, "reset_dout");
        step(1'b0, 1'b1, 1'b0, 5'd3, 32'h0, "reset_blocked_write");

        for (int i = 0; i < 17; i++)
            step(1'b0, 1'b1, 1'b1, 5'(i), seq_data[i], "seq_write");
        for (int i = 16; i >= 0; i--)
            step(1'b0, 1'b1, 1'b0, 5'(i), 32'h0, "reverse_read");

        step(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, "idle_dout");
        step(1'b0, 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, "idle_no_write");
        step(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, "idle_retain");

        step(1'b0, 1'b1, 1'b1, 5'd0, 32'h16, "overwrite");
        step(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, "write_then_read");

        for (int i = 0; i < 32; i++)
            step(1'b0, 1'b1, 1'b1, 5'(i), 32'hA5A5_0000 + 32'(i), "full_write");
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b1, 1'b0, 5'(i), 32'h0, "full_read");
            if (i == 0) d0 = dout;
            if (i == 31) d31 = dout;
        end
        checks++;
        assert (d31 !== d0) else begin
            errors++;
            $error("FAIL addr31_distinct: addr31=%h addr0=%h", d31, d0);
        end

        // Randomised mix of operations with occasional reset.
        for (int n = 0; n < 400; n++) begin
            int kind;
            kind = $urandom_range(0, 99);
            if (kind < 2)
                step(1'b1, 1'($urandom), 1'($urandom), 5'($urandom), $urandom, "rand_reset");
            else if (kind < 15)
                step(1'b0, 1'b0, 1'($urandom), 5'($urandom), $urandom, "rand_idle");
            else if (kind < 55)
                step(1'b0, 1'b1, 1'b1, 5'($urandom), $urandom, "rand_write");
            else
                step(1'b0, 1'b1, 1'b0, 5'($urandom), 32'h0, "rand_read");
        end

        // Contents lost after reset mid-sequence.
        step(1'b0, 1'b1, 1'b1, 5'd31, 32'h1234_5678, "pre_reset_write");
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, "mid_reset");
        step(1'b0, 1'b1, 1'b0, 5'd31, 32'h0, "post_reset_read");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
